// File: rtl/fpga_board_io_pkg.sv
// Shared constants and helpers for the board I/O controller.
package fpga_board_io_pkg;

    // Edge types that can set a channel's pending flag
    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    localparam int unsigned DEF_N_IN      = 7;
    localparam int unsigned DEF_N_OUT     = 4;
    localparam int unsigned DEF_DB_CYCLES = 500000;
    localparam int unsigned DEF_PWM_W     = 8;

    // True when the given pulses contain an edge the mode cares about
    function automatic logic edge_hit(input edge_mode_e mode, input logic rise, input logic fall);
        case (mode)
            EDGE_RISE: return rise;
            EDGE_FALL: return fall;
            default:   return rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/fpga_board_io_ctrl_if.sv
// Board I/O signal bundle: debounced inputs, pending flags and LED PWM controls.
interface fpga_board_io_ctrl_if
    import fpga_board_io_pkg::*;
#(
    parameter int unsigned N_IN  = DEF_N_IN,
    parameter int unsigned N_OUT = DEF_N_OUT,
    parameter int unsigned PWM_W = DEF_PWM_W
);
    logic [N_IN-1:0]        in_raw_i;
    logic [N_IN-1:0]        in_level_o;
    logic [N_IN-1:0]        in_rise_o;
    logic [N_IN-1:0]        in_fall_o;
    logic [N_IN-1:0]        pend_o;
    logic [N_IN-1:0]        pend_clr_i;
    logic                   irq_o;
    logic [N_OUT-1:0]       led_en_i;
    logic [N_OUT*PWM_W-1:0] led_duty_i;
    logic [N_OUT-1:0]       led_o;

    // Controller side
    modport slave (
        input  in_raw_i, pend_clr_i, led_en_i, led_duty_i,
        output in_level_o, in_rise_o, in_fall_o, pend_o, irq_o, led_o
    );

    // Host / board side
    modport master (
        output in_raw_i, pend_clr_i, led_en_i, led_duty_i,
        input  in_level_o, in_rise_o, in_fall_o, pend_o, irq_o, led_o
    );
endinterface

// File: rtl/board_io_debounce.sv
// One input channel: 2-flop synchroniser, stability counter and edge pulses.
module board_io_debounce
    import fpga_board_io_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Count cycles the synchronised input disagrees with the accepted level; toggle once stable long enough
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser and debounce state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/fpga_board_io_ctrl.sv
// Board I/O controller: debounced inputs with sticky event flags and PWM LED drivers.
module fpga_board_io_ctrl
    import fpga_board_io_pkg::*;
#(
    parameter int unsigned N_IN      = DEF_N_IN,
    parameter int unsigned N_OUT     = DEF_N_OUT,
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
    parameter int unsigned PWM_W     = DEF_PWM_W,
    parameter edge_mode_e  EDGE_MODE = EDGE_BOTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fpga_board_io_ctrl_if.slave   io
);
    logic [N_IN-1:0]        level_w, rise_w, fall_w;
    logic [N_IN-1:0]        pend_q, pend_d;
    logic [PWM_W-1:0]       pwm_cnt_q, pwm_cnt_d;
    logic [N_OUT*PWM_W-1:0] shadow_q, shadow_d;
    logic [N_OUT-1:0]       led_q, led_d;

    for (genvar g = 0; g < N_IN; g++) begin : g_ch
        board_io_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .raw_i   (io.in_raw_i[g]),
            .level_o (level_w[g]),
            .rise_o  (rise_w[g]),
            .fall_o  (fall_w[g])
        );
    end

    // Pending flags: a selected edge wins over a simultaneous clear
    always_comb begin
        pend_d = pend_q;
        for (int unsigned i = 0; i < N_IN; i++) begin
            pend_d[i] = (pend_q[i] & ~io.pend_clr_i[i]) | edge_hit(EDGE_MODE, rise_w[i], fall_w[i]);
        end
    end

    // PWM: free-running counter, duty shadowed at wrap, registered compare
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        shadow_d  = (pwm_cnt_q == '1) ? io.led_duty_i : shadow_q;
        led_d     = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            led_d[k] = io.led_en_i[k] & (pwm_cnt_q < shadow_q[k*PWM_W +: PWM_W]);
        end
    end

    // Pending and PWM state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q    <= '0;
            pwm_cnt_q <= '0;
            shadow_q  <= '0;
            led_q     <= '0;
        end else begin
            pend_q    <= pend_d;
            pwm_cnt_q <= pwm_cnt_d;
            shadow_q  <= shadow_d;
            led_q     <= led_d;
        end
    end

    assign io.in_level_o = level_w;
    assign io.in_rise_o  = rise_w;
    assign io.in_fall_o  = fall_w;
    assign io.pend_o     = pend_q;
    assign io.irq_o      = |pend_q;
    assign io.led_o      = led_q;
endmodule

// File: tb/tb_fpga_board_io_ctrl.sv
// Directed bench for fpga_board_io_ctrl with an expected-value scoreboard.
module tb_fpga_board_io_ctrl;
    import fpga_board_io_pkg::*;

    localparam int unsigned N_IN  = 7;
    localparam int unsigned N_OUT = 4;
    localparam int unsigned PWM_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ecount;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] exp_q[$];
    string       tag_q[$];

    fpga_board_io_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT), .PWM_W(PWM_W)) bus ();

    fpga_board_io_ctrl #(
        .N_IN      (N_IN),
        .N_OUT     (N_OUT),
        .DB_CYCLES (4),
        .PWM_W     (PWM_W),
        .EDGE_MODE (EDGE_BOTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .io    (bus)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the PWM counter equals this value mod 16
    always @(posedge clk or posedge rst) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [63:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [63:0] obs);
        logic [63:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    // Step until the sample reflects PWM count 0, passing at least one wrap first
    task automatic align();
        repeat (2) step();
        for (int n = 0; n < 20 && (ecount % 16) != 1; n++) step();
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.in_level_o, bus.in_rise_o, bus.in_fall_o, bus.pend_o, bus.irq_o, bus.led_o});
    endfunction

    initial begin
        bus.in_raw_i   = '1;
        bus.pend_clr_i = '0;
        bus.led_en_i   = '0;
        bus.led_duty_i = '0;

        // Reset: everything held low even with inputs high
        repeat (2) begin
            step();
            push("reset_outputs", 64'd0);
            check(all_outs());
        end
        bus.in_raw_i = '0;
        step();
        rst = 1'b0;

        // Channel 0 rising edge: level after 6 cycles, one rise pulse, pend and irq follow
        bus.in_raw_i[0] = 1'b1;
        for (int k = 1; k <= 8; k++)
            push("ch0_rise", 64'({k >= 6, k == 6, k >= 7, k >= 7}));
        for (int k = 1; k <= 8; k++) begin
            step();
            check(64'({bus.in_level_o[0], bus.in_rise_o[0], bus.pend_o[0], bus.irq_o}));
        end

        // Channel 1 glitch of 3 cycles is discarded
        bus.in_raw_i[1] = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            if (k == 4) bus.in_raw_i[1] = 1'b0;
            push("ch1_glitch", 64'd0);
            step();
            check(64'({bus.in_level_o[1], bus.in_rise_o[1], bus.in_fall_o[1], bus.pend_o[1]}));
        end

        // Clear alone, then clear coincident with a fall (set wins), then clear alone again
        bus.pend_clr_i[0] = 1'b1;
        step();
        bus.pend_clr_i[0] = 1'b0;
        push("ch0_clear", 64'd0);
        check(64'({bus.pend_o[0], bus.irq_o}));
        bus.in_raw_i[0] = 1'b0;
        for (int k = 1; k <= 8; k++)
            push("ch0_fall_clr", (k < 6) ? 64'b1000 : (k == 6) ? 64'b0100 : (k == 7) ? 64'b0011 : 64'b0000);
        for (int k = 1; k <= 8; k++) begin
            step();
            check(64'({bus.in_level_o[0], bus.in_fall_o[0], bus.pend_o[0], bus.irq_o}));
            if (k == 6) bus.pend_clr_i[0] = 1'b1;
            if (k == 8) bus.pend_clr_i[0] = 1'b0;
        end

        // PWM duty 5 / 0 / 15 on LED 0; LED 3 has duty but is disabled
        bus.led_en_i   = 4'b0001;
        bus.led_duty_i = {4'd8, 4'd0, 4'd0, 4'd5};
        align();
        for (int k = 0; k < 16; k++) begin
            push("pwm_duty5", 64'(k < 5));
            check(64'(bus.led_o));
            step();
        end
        bus.led_duty_i = {4'd8, 4'd0, 4'd0, 4'd0};
        align();
        for (int k = 0; k < 16; k++) begin
            push("pwm_duty0", 64'd0);
            check(64'(bus.led_o));
            step();
        end
        bus.led_duty_i = {4'd8, 4'd0, 4'd0, 4'd15};
        align();
        for (int k = 0; k < 16; k++) begin
            push("pwm_duty15", 64'(k < 15));
            check(64'(bus.led_o));
            step();
        end

        // Enable drop takes effect next cycle
        align();
        step();
        push("pwm_en_on", 64'd1);
        check(64'(bus.led_o));
        bus.led_en_i[0] = 1'b0;
        step();
        push("pwm_en_off", 64'd0);
        check(64'(bus.led_o));

        // Duty change mid-period applies from the next period
        bus.led_en_i[0] = 1'b1;
        bus.led_duty_i  = {4'd8, 4'd0, 4'd0, 4'd3};
        align();
        for (int k = 0; k < 32; k++)
            push("pwm_duty_change", 64'((k < 16) ? (k < 3) : ((k - 16) < 12)));
        for (int k = 0; k < 32; k++) begin
            check(64'(bus.led_o));
            if (k == 5) bus.led_duty_i = {4'd8, 4'd0, 4'd0, 4'd12};
            step();
        end

        // Input held high through a mid-operation reset rises 6 cycles after release
        bus.in_raw_i[2] = 1'b1;
        step();
        rst = 1'b1;
        repeat (3) begin
            step();
            push("midrun_reset_outputs", 64'd0);
            check(all_outs());
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++)
            push("ch2_reset_rise", 64'({k >= 6, k == 6}));
        for (int k = 1; k <= 8; k++) begin
            step();
            check(64'({bus.in_level_o[2], bus.in_rise_o[2]}));
        end

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
